// File: rtl/clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_ctrl
// Description : Programmable integer clock-divider controller. Produces a
//               registered divided clock (clkout) and a one-cycle rising-edge
//               pulse (tick) from clkin. Start, stop and divisor changes are
//               sequenced so that every clkout period is complete.
//               Optional macro CLKDIV_CTRL_EDGE_CNT_EN builds a 16-bit tick
//               counter on edge_cnt; otherwise edge_cnt is tied to 0.
// Ports       : clkin      - system clock, all logic on rising edge
//               rst        - synchronous active-high reset
//               en         - run level; 0 stops after the current period
//               cfg_valid  - divisor offered
//               cfg_div    - offered divisor N
//               cfg_ready  - divisor can be accepted this cycle
//               cfg_err    - one-cycle pulse: accepted divisor < 2 discarded
//               clkout     - registered divided clock
//               tick       - registered pulse in the cycle clkout rises
//               busy       - 1 in RUN, PEND, STOP
//               edge_cnt   - count of tick pulses (optional feature)
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_ctrl #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clkout,
  output logic             tick,
  output logic             busy,
  output logic [15:0]      edge_cnt
);

  localparam logic [DIV_W-1:0] c_MIN_DIV = DIV_W'(2);
  localparam logic [DIV_W-1:0] c_RST_DIV = DIV_W'(DEFAULT_DIV);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PEND = 2'd2,
    S_STOP = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             clkout_q, clkout_d;
  logic             tick_q, tick_d;
  logic             cfg_err_q, cfg_err_d;

  logic             w_xfer;
  logic             w_good;
  logic             w_last;
  logic [DIV_W-1:0] w_cnt_inc;

  assign cfg_ready = (state_q == S_IDLE) || (state_q == S_RUN);
  assign busy      = (state_q != S_IDLE);
  assign clkout    = clkout_q;
  assign tick      = tick_q;
  assign cfg_err   = cfg_err_q;

  assign w_xfer    = cfg_valid && cfg_ready;
  assign w_good    = w_xfer && (cfg_div >= c_MIN_DIV);
  assign w_last    = (cnt_q == (div_q - 1'b1));
  assign w_cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    tick_d     = 1'b0;
    cfg_err_d  = w_xfer && (cfg_div < c_MIN_DIV);

    case (state_q)
      S_IDLE: begin
        cnt_d      = '0;
        pend_vld_d = 1'b0;
        // A divisor accepted on the same edge as en governs the first period.
        if (w_good) div_d = cfg_div;
        if (en) begin
          state_d = S_RUN;
          tick_d  = 1'b1;
        end
      end

      S_RUN: begin
        cnt_d = w_last ? '0 : w_cnt_inc;
        if (!en) begin
          if (w_last) begin
            // Period ends on this very edge: finish straight into IDLE
            // rather than starting a period that would have no tick.
            state_d = S_IDLE;
            if (w_good) div_d = cfg_div;
          end else begin
            state_d = S_STOP;
            if (w_good) begin
              pend_d     = cfg_div;
              pend_vld_d = 1'b1;
            end
          end
        end else begin
          if (w_last) tick_d = 1'b1;
          if (w_good) begin
            // New divisor waits for the next boundary, even if this edge wraps.
            pend_d     = cfg_div;
            pend_vld_d = 1'b1;
            state_d    = S_PEND;
          end
        end
      end

      S_PEND: begin
        cnt_d = w_last ? '0 : w_cnt_inc;
        if (w_last) begin
          div_d      = pend_q;
          pend_vld_d = 1'b0;
          if (en) begin
            state_d = S_RUN;
            tick_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else if (!en) begin
          state_d = S_STOP;
        end
      end

      S_STOP: begin
        cnt_d = w_last ? '0 : w_cnt_inc;
        if (w_last) begin
          if (pend_vld_q) div_d = pend_q;
          pend_vld_d = 1'b0;
          state_d    = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    clkout_d = (state_d != S_IDLE) && (cnt_d < (div_d >> 1));
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      state_q    <= S_IDLE;
      div_q      <= c_RST_DIV;
      cnt_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      clkout_q   <= 1'b0;
      tick_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      clkout_q   <= clkout_d;
      tick_q     <= tick_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

`ifdef CLKDIV_CTRL_EDGE_CNT_EN
  logic [15:0] edge_cnt_q;

  // Counts on tick_d so edge_cnt steps on the same edge tick rises.
  always_ff @(posedge clkin) begin
    if (rst) begin
      edge_cnt_q <= '0;
    end else if (tick_d) begin
      edge_cnt_q <= edge_cnt_q + 16'd1;
    end
  end

  assign edge_cnt = edge_cnt_q;
`else
  assign edge_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_ctrl
// Description : Directed self-checking bench for clk_div_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_ctrl;

  logic       clkin = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_div = 8'd0;
  logic       cfg_ready, cfg_err, clkout, tick, busy;
  logic [15:0] edge_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  clk_div_ctrl #(.DIV_W(8), .DEFAULT_DIV(2)) dut (
    .clkin(clkin), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .clkout(clkout), .tick(tick),
    .busy(busy), .edge_cnt(edge_cnt)
  );

  always #5 clkin = ~clkin;

  task automatic cyc();
    @(posedge clkin);
    #1;
  endtask

  task automatic load_idle(input logic [7:0] n);
    cfg_valid = 1'b1; cfg_div = n;
    cyc();
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0;
    cyc(); cyc();
    n_checks++; if (clkout !== 1'b0) begin n_fail++; $display("FAIL reset_clkout: got %b exp 0", clkout); end
    n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b exp 0", tick); end
    n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_err: got %b exp 0", cfg_err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy); end
    n_checks++; if (edge_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_edge_cnt: got %0d exp 0", edge_cnt); end
    rst = 1'b0;
    cyc();
    n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cfg_ready: got %b exp 1", cfg_ready); end
  endtask

  task automatic test_div2();
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      n_checks++; if (clkout !== (i % 2 == 0)) begin n_fail++; $display("FAIL div2_clkout[%0d]: got %b exp %b", i, clkout, (i % 2 == 0)); end
      n_checks++; if (tick !== (i % 2 == 0)) begin n_fail++; $display("FAIL div2_tick[%0d]: got %b exp %b", i, tick, (i % 2 == 0)); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL div2_busy[%0d]: got %b exp 1", i, busy); end
    end
    // Last sample was the final cycle of a period: stop lands in IDLE at once.
    en = 1'b0;
    cyc();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL div2_stop_busy: got %b exp 0", busy); end
    n_checks++; if (clkout !== 1'b0 || tick !== 1'b0) begin n_fail++; $display("FAIL div2_stop_out: got clk %b tick %b exp 0 0", clkout, tick); end
  endtask

  task automatic test_div5();
    load_idle(8'd5);
    n_checks++; if (cfg_err !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL div5_load: got err %b busy %b exp 0 0", cfg_err, busy); end
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      n_checks++; if (clkout !== ((i % 5) < 2)) begin n_fail++; $display("FAIL div5_clkout[%0d]: got %b exp %b", i, clkout, ((i % 5) < 2)); end
      n_checks++; if (tick !== (i % 5 == 0)) begin n_fail++; $display("FAIL div5_tick[%0d]: got %b exp %b", i, tick, (i % 5 == 0)); end
    end
    en = 1'b0;
    cyc();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL div5_stop_busy: got %b exp 0", busy); end
  endtask

  task automatic test_pend();
    load_idle(8'd4);
    en = 1'b1;
    cyc(); cyc();                      // cnt=1 now
    n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL pend_ready_run: got %b exp 1", cfg_ready); end
    cfg_valid = 1'b1; cfg_div = 8'd3;
    cyc();                             // cnt=2, PEND
    cfg_valid = 1'b0;
    n_checks++; if (cfg_ready !== 1'b0 || clkout !== 1'b0 || tick !== 1'b0) begin n_fail++; $display("FAIL pend_cnt2: got rdy %b clk %b tick %b exp 0 0 0", cfg_ready, clkout, tick); end
    cyc();                             // cnt=3
    n_checks++; if (cfg_ready !== 1'b0 || clkout !== 1'b0 || tick !== 1'b0) begin n_fail++; $display("FAIL pend_cnt3: got rdy %b clk %b tick %b exp 0 0 0", cfg_ready, clkout, tick); end
    cyc();                             // boundary, new N=3
    n_checks++; if (cfg_ready !== 1'b1 || clkout !== 1'b1 || tick !== 1'b1) begin n_fail++; $display("FAIL pend_boundary: got rdy %b clk %b tick %b exp 1 1 1", cfg_ready, clkout, tick); end
    for (int i = 1; i < 6; i++) begin
      cyc();
      n_checks++; if (clkout !== (i % 3 == 0) || tick !== (i % 3 == 0)) begin n_fail++; $display("FAIL pend_div3[%0d]: got clk %b tick %b exp %b", i, clkout, tick, (i % 3 == 0)); end
    end
    en = 1'b0;
    cyc();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pend_stop_busy: got %b exp 0", busy); end
  endtask

  task automatic test_stop();
    load_idle(8'd6);
    en = 1'b1;
    cyc(); cyc(); cyc();               // cnt=2
    n_checks++; if (clkout !== 1'b1) begin n_fail++; $display("FAIL stop_cnt2_clk: got %b exp 1", clkout); end
    en = 1'b0;
    cyc();                             // STOP, cnt=3
    n_checks++; if (busy !== 1'b1 || cfg_ready !== 1'b0 || clkout !== 1'b0) begin n_fail++; $display("FAIL stop_cnt3: got busy %b rdy %b clk %b exp 1 0 0", busy, cfg_ready, clkout); end
    en = 1'b1;                         // ignored until IDLE
    cyc(); cyc();                      // cnt=4,5
    n_checks++; if (busy !== 1'b1 || clkout !== 1'b0 || tick !== 1'b0) begin n_fail++; $display("FAIL stop_cnt5: got busy %b clk %b tick %b exp 1 0 0", busy, clkout, tick); end
    cyc();                             // boundary -> IDLE
    n_checks++; if (busy !== 1'b0 || clkout !== 1'b0 || tick !== 1'b0) begin n_fail++; $display("FAIL stop_idle: got busy %b clk %b tick %b exp 0 0 0", busy, clkout, tick); end
    cyc();                             // en honoured, restart cnt=0
    n_checks++; if (busy !== 1'b1 || clkout !== 1'b1 || tick !== 1'b1) begin n_fail++; $display("FAIL stop_restart: got busy %b clk %b tick %b exp 1 1 1", busy, clkout, tick); end
    en = 1'b0;
    begin : wait_idle
      for (int i = 0; i < 20; i++) begin
        cyc();
        if (busy === 1'b0) disable wait_idle;
      end
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_wait_idle: got busy %b exp 0", busy); end
  endtask

  task automatic test_err();
    load_idle(8'd4);
    en = 1'b1;
    cyc();                             // cnt=0
    cfg_valid = 1'b1; cfg_div = 8'd1;
    cyc();                             // cnt=1
    cfg_valid = 1'b0;
    n_checks++; if (cfg_err !== 1'b1 || cfg_ready !== 1'b1) begin n_fail++; $display("FAIL err_div1: got err %b rdy %b exp 1 1", cfg_err, cfg_ready); end
    cyc();                             // cnt=2
    n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL err_pulse_end: got %b exp 0", cfg_err); end
    cfg_valid = 1'b1; cfg_div = 8'd0;
    cyc();                             // cnt=3
    cfg_valid = 1'b0;
    n_checks++; if (cfg_err !== 1'b1 || clkout !== 1'b0) begin n_fail++; $display("FAIL err_div0: got err %b clk %b exp 1 0", cfg_err, clkout); end
    cyc();                             // period unchanged: wrap at 4
    n_checks++; if (cfg_err !== 1'b0 || tick !== 1'b1 || clkout !== 1'b1) begin n_fail++; $display("FAIL err_period: got err %b tick %b clk %b exp 0 1 1", cfg_err, tick, clkout); end
    cyc(); cyc();                      // cnt=2
    n_checks++; if (clkout !== 1'b0 || tick !== 1'b0) begin n_fail++; $display("FAIL err_cnt2: got clk %b tick %b exp 0 0", clkout, tick); end
    en = 1'b0;
    cyc(); cyc();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL err_stop: got busy %b exp 0", busy); end
  endtask

  task automatic test_same_edge();
    cfg_valid = 1'b1; cfg_div = 8'd3; en = 1'b1;
    cyc();
    cfg_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) cyc();
      n_checks++; if (clkout !== (i % 3 == 0) || tick !== (i % 3 == 0)) begin n_fail++; $display("FAIL same_edge[%0d]: got clk %b tick %b exp %b", i, clkout, tick, (i % 3 == 0)); end
    end
    en = 1'b0;
    cyc();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL same_edge_stop: got busy %b exp 0", busy); end
  endtask

  task automatic test_reset_mid();
    load_idle(8'd7);
    en = 1'b1;
    cyc(); cyc(); cyc();               // cnt=2 with N=7
    cfg_valid = 1'b1; cfg_div = 8'd5;  // goes pending, then discarded by reset
    cyc();
    cfg_valid = 1'b0;
    rst = 1'b1;
    cyc();
    n_checks++; if (clkout !== 1'b0 || tick !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_out: got clk %b tick %b busy %b exp 0 0 0", clkout, tick, busy); end
    n_checks++; if (edge_cnt !== 16'd0) begin n_fail++; $display("FAIL rstmid_edge_cnt: got %0d exp 0", edge_cnt); end
    rst = 1'b0;
    // Divisor back to 2: 1,0,1,0
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_checks++; if (clkout !== (i % 2 == 0) || tick !== (i % 2 == 0)) begin n_fail++; $display("FAIL rstmid_div2[%0d]: got clk %b tick %b exp %b", i, clkout, tick, (i % 2 == 0)); end
    end
    en = 1'b0;
    cyc();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_stop: got busy %b exp 0", busy); end
  endtask

  task automatic test_edge_cnt();
    rst = 1'b1; cyc(); rst = 1'b0;
    en = 1'b1;
    cyc();
`ifdef CLKDIV_CTRL_EDGE_CNT_EN
    n_checks++; if (edge_cnt !== 16'd1) begin n_fail++; $display("FAIL edgecnt_first: got %0d exp 1", edge_cnt); end
    for (int i = 1; i < 131072; i++) cyc();
    n_checks++; if (edge_cnt !== 16'd0) begin n_fail++; $display("FAIL edgecnt_wrap: got %0d exp 0", edge_cnt); end
    cyc();
    n_checks++; if (edge_cnt !== 16'd1) begin n_fail++; $display("FAIL edgecnt_after_wrap: got %0d exp 1", edge_cnt); end
`else
    for (int i = 0; i < 50; i++) begin
      cyc();
      n_checks++; if (edge_cnt !== 16'd0) begin n_fail++; $display("FAIL edgecnt_zero[%0d]: got %0d exp 0", i, edge_cnt); end
    end
`endif
    en = 1'b0;
    cyc(); cyc();
  endtask

  initial begin
    test_reset();
    test_div2();
    test_div5();
    test_pend();
    test_stop();
    test_err();
    test_same_edge();
    test_reset_mid();
    test_edge_cnt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
